// File: rtl/rx_pattern_checker.sv
// Checks received words against a down-counting pattern, counts words and errors,
// and latches a pass/fail verdict (plus LED) when the sender closes the burst.
module rx_pattern_checker #(
    parameter int unsigned EXPECT_COUNT = 100,
    parameter logic [31:0] SEED         = 32'hFFFF_FFFF,
    parameter bit          LOCK_FIRST   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    input  logic        send_done,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic        led,
    output logic [15:0] word_count,
    output logic [15:0] err_count,
    output logic [31:0] first_err_data
);

    localparam logic [15:0] EXP_CNT = EXPECT_COUNT[15:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counters stick at all-ones instead of wrapping back to a small value.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    state_t      state_q, state_d;
    logic [31:0] exp_q, exp_d;
    logic [15:0] wc_q, wc_d;
    logic [15:0] ec_q, ec_d;
    logic [31:0] first_q, first_d;
    logic        mism_seen_q, mism_seen_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        busy_q, busy_d;
    logic        led_q, led_d;

    logic [31:0] ref_s;
    logic        mism_s;
    logic        ovr_s;
    logic [15:0] wc_tmp_s;
    logic [15:0] ec_tmp_s;

    // Next-state logic: word check first, then end-of-burst check on the updated counts.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        wc_d        = wc_q;
        ec_d        = ec_q;
        first_d     = first_q;
        mism_seen_d = mism_seen_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        wc_tmp_s    = wc_q;
        ec_tmp_s    = ec_q;
        // With LOCK_FIRST the very first word is its own reference and seeds the sequence.
        ref_s       = (LOCK_FIRST && (state_q == S_IDLE)) ? data_in : exp_q;
        mism_s      = (data_in != ref_s);
        ovr_s       = (wc_q >= EXP_CNT);

        if (clear) begin
            state_d     = S_IDLE;
            exp_d       = SEED;
            wc_d        = 16'd0;
            ec_d        = 16'd0;
            first_d     = 32'd0;
            mism_seen_d = 1'b0;
            pass_d      = 1'b0;
            fail_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_RUN: begin
                    if (data_valid) begin
                        wc_tmp_s = sat_add(wc_q, 2'd1);
                        ec_tmp_s = sat_add(ec_q, {1'b0, mism_s} + {1'b0, ovr_s});
                        exp_d    = ref_s - 32'd1;
                        state_d  = S_RUN;
                        if (mism_s && !mism_seen_q) begin
                            first_d     = data_in;
                            mism_seen_d = 1'b1;
                        end else begin
                            first_d     = first_q;
                        end
                    end else begin
                        wc_tmp_s = wc_q;
                    end
                    if (send_done) begin
                        if (wc_tmp_s != EXP_CNT) begin
                            ec_tmp_s = sat_add(ec_tmp_s, 2'd1);
                        end else begin
                            ec_tmp_s = ec_tmp_s;
                        end
                        state_d = S_DONE;
                        pass_d  = (ec_tmp_s == 16'd0);
                        fail_d  = (ec_tmp_s != 16'd0);
                    end else begin
                        pass_d  = pass_q;
                    end
                    wc_d = wc_tmp_s;
                    ec_d = ec_tmp_s;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_RUN);
        led_d  = pass_d;
    end

    // State and output registers; rst outranks everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            exp_q       <= SEED;
            wc_q        <= 16'd0;
            ec_q        <= 16'd0;
            first_q     <= 32'd0;
            mism_seen_q <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            busy_q      <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            wc_q        <= wc_d;
            ec_q        <= ec_d;
            first_q     <= first_d;
            mism_seen_q <= mism_seen_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            busy_q      <= busy_d;
            led_q       <= led_d;
        end
    end

    assign busy           = busy_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign led            = led_q;
    assign word_count     = wc_q;
    assign err_count      = ec_q;
    assign first_err_data = first_q;

endmodule

// File: tb/tb_rx_pattern_checker.sv
// Bench for rx_pattern_checker: a default instance and a LOCK_FIRST/EXPECT_COUNT=4
// instance, each checked every cycle against a behavioural burst model.
module tb_rx_pattern_checker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_clr, a_dv, a_sd;
    logic [31:0] a_d;
    logic        a_busy, a_pass, a_fail, a_led;
    logic [15:0] a_wc, a_ec;
    logic [31:0] a_fe;

    logic        b_rst, b_clr, b_dv, b_sd;
    logic [31:0] b_d;
    logic        b_busy, b_pass, b_fail, b_led;
    logic [15:0] b_wc, b_ec;
    logic [31:0] b_fe;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    rx_pattern_checker u_a (
        .clk(clk), .rst(a_rst), .clear(a_clr), .data_in(a_d), .data_valid(a_dv),
        .send_done(a_sd), .busy(a_busy), .pass(a_pass), .fail(a_fail), .led(a_led),
        .word_count(a_wc), .err_count(a_ec), .first_err_data(a_fe)
    );

    rx_pattern_checker #(.EXPECT_COUNT(4), .SEED(32'hFFFF_FFFF), .LOCK_FIRST(1'b1)) u_b (
        .clk(clk), .rst(b_rst), .clear(b_clr), .data_in(b_d), .data_valid(b_dv),
        .send_done(b_sd), .busy(b_busy), .pass(b_pass), .fail(b_fail), .led(b_led),
        .word_count(b_wc), .err_count(b_ec), .first_err_data(b_fe)
    );

    // Reference model: unbounded word/error totals, clamped only when compared.
    typedef struct packed {
        int          phase;   // 0 idle, 1 running, 2 verdict given
        int          words;
        int          errs;
        bit          have;
        logic [31:0] first;
        logic [31:0] expv;
        bit          pass;
        bit          fail;
    } mdl_t;

    mdl_t ma, mb;

    function automatic int clamp16(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int ec, input bit lock,
                                   input logic [31:0] seed, input bit r, input bit c,
                                   input bit v, input bit s, input logic [31:0] d);
        logic [31:0] refv;
        if (r || c) begin
            m = '0;
            m.expv = seed;
            return m;
        end
        if (m.phase == 2) return m;
        if (v) begin
            refv = (lock && m.phase == 0) ? d : m.expv;
            if (d != refv) begin
                m.errs++;
                if (!m.have) begin
                    m.have  = 1'b1;
                    m.first = d;
                end
            end
            if (m.words >= ec) m.errs++;
            m.words++;
            m.expv  = refv - 32'd1;
            m.phase = 1;
        end
        if (s) begin
            if (clamp16(m.words) != ec) m.errs++;
            m.phase = 2;
            m.pass  = (m.errs == 0);
            m.fail  = (m.errs != 0);
        end
        return m;
    endfunction

    always @(posedge clk) begin
        ma <= mstep(ma, 100, 1'b0, 32'hFFFF_FFFF, a_rst, a_clr, a_dv, a_sd, a_d);
        mb <= mstep(mb, 4,   1'b1, 32'hFFFF_FFFF, b_rst, b_clr, b_dv, b_sd, b_d);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input mdl_t m, input logic busy, input logic pass,
                            input logic fail, input logic led, input logic [15:0] wc,
                            input logic [15:0] ec, input logic [31:0] fe);
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (m.phase == 1)});
        chk({tag, "_pass"}, {31'd0, pass}, {31'd0, m.pass});
        chk({tag, "_fail"}, {31'd0, fail}, {31'd0, m.fail});
        chk({tag, "_led"},  {31'd0, led},  {31'd0, m.pass});
        chk({tag, "_wc"},   {16'd0, wc},   32'(clamp16(m.words)));
        chk({tag, "_ec"},   {16'd0, ec},   32'(clamp16(m.errs)));
        chk({tag, "_fe"},   fe,            m.have ? m.first : 32'd0);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst("a", ma, a_busy, a_pass, a_fail, a_led, a_wc, a_ec, a_fe);
            cmp_inst("b", mb, b_busy, b_pass, b_fail, b_led, b_wc, b_ec, b_fe);
        end
    end

    task automatic tick(input int inst, input bit r, input bit c, input bit v, input bit s,
                        input logic [31:0] d);
        @(negedge clk);
        a_rst = 1'b0; a_clr = 1'b0; a_dv = 1'b0; a_sd = 1'b0; a_d = 32'd0;
        b_rst = 1'b0; b_clr = 1'b0; b_dv = 1'b0; b_sd = 1'b0; b_d = 32'd0;
        if (inst == 0) begin
            a_rst = r; a_clr = c; a_dv = v; a_sd = s; a_d = d;
        end else begin
            b_rst = r; b_clr = c; b_dv = v; b_sd = s; b_d = d;
        end
    endtask

    task automatic idle(input int inst);
        tick(inst, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Down-counting burst on instance A, optionally corrupting one word.
    task automatic burst_a(input int n, input int bad_idx, input logic [31:0] bad, input bit sd_last);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = 32'hFFFF_FFFF - 32'(i);
            if (i == bad_idx) d = bad;
            tick(0, 1'b0, 1'b0, 1'b1, sd_last && (i == n - 1), d);
        end
        if (!sd_last) tick(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        idle(0);
    endtask

    task automatic rand_burst(input int inst, input int nom, input logic [31:0] v0);
        int          n;
        bit          done;
        bit          s;
        logic [31:0] v;
        logic [31:0] d;
        tick(inst, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        n    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(nom - 2, nom + 2));
        v    = v0;
        done = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle(inst);
            if ($urandom_range(0, 299) == 0) begin
                tick(inst, $urandom_range(0, 1) == 1, 1'b1, 1'b1, 1'b0, v);
                done = 1'b1;
                break;
            end
            d = ($urandom_range(0, 24) == 0) ? $urandom : v;
            s = (i == n - 1) && ($urandom_range(0, 2) == 0);
            tick(inst, 1'b0, 1'b0, 1'b1, s, d);
            v = v - 32'd1;
            done = done | s;
        end
        if (!done) tick(inst, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(inst, 1'b0, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_clr = 1'b0; a_dv = 1'b0; a_sd = 1'b0; a_d = 32'd0;
        b_rst = 1'b1; b_clr = 1'b0; b_dv = 1'b0; b_sd = 1'b0; b_d = 32'd0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        idle(0);
        chk("reset_wc", {16'd0, a_wc}, 32'd0);
        chk("reset_pass_fail", {30'd0, a_pass, a_fail}, 32'd0);
        chk("reset_b_busy", {31'd0, b_busy}, 32'd0);

        tick(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        burst_a(100, -1, 32'd0, 1'b0);
        chk("clean_wc", {16'd0, a_wc}, 32'd100);
        chk("clean_ec", {16'd0, a_ec}, 32'd0);
        chk("clean_pass_led", {30'd0, a_pass, a_led}, 32'd3);

        tick(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        burst_a(100, 10, 32'h1234_5678, 1'b0);
        chk("corrupt_ec", {16'd0, a_ec}, 32'd1);
        chk("corrupt_fe", a_fe, 32'h1234_5678);
        chk("corrupt_fail", {31'd0, a_fail}, 32'd1);

        tick(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        burst_a(99, -1, 32'd0, 1'b0);
        chk("short_ec", {16'd0, a_ec}, 32'd1);
        chk("short_fail", {31'd0, a_fail}, 32'd1);

        tick(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        burst_a(101, -1, 32'd0, 1'b0);
        chk("overrun_ec", {16'd0, a_ec}, 32'd2);
        chk("overrun_wc", {16'd0, a_wc}, 32'd101);

        tick(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        tick(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        idle(0);
        chk("empty_ec", {16'd0, a_ec}, 32'd1);
        chk("empty_fail", {31'd0, a_fail}, 32'd1);

        tick(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        burst_a(100, -1, 32'd0, 1'b1);
        chk("simul_wc", {16'd0, a_wc}, 32'd100);
        chk("simul_pass", {31'd0, a_pass}, 32'd1);

        tick(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 50; i++) tick(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF - 32'(i));
        tick(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFCE);
        idle(0);
        chk("midrst_wc", {16'd0, a_wc}, 32'd0);
        chk("midrst_busy", {31'd0, a_busy}, 32'd0);
        burst_a(100, -1, 32'd0, 1'b0);
        chk("after_rst_pass", {31'd0, a_pass}, 32'd1);

        tick(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        tick(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0001);
        tick(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000);
        tick(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        tick(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE);
        tick(1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        idle(1);
        chk("lock_pass", {31'd0, b_pass}, 32'd1);
        chk("lock_ec", {16'd0, b_ec}, 32'd0);

        for (int r = 0; r < 12; r++) rand_burst(0, 100, 32'hFFFF_FFFF);
        for (int r = 0; r < 40; r++) rand_burst(1, 4, $urandom);
        idle(0);
        idle(0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
